// File: rtl/ysyx_25040101_inst_pack_pkg.sv
// rtl/ysyx_25040101_inst_pack_pkg.sv - shared immediate-type constants and packer types
package ysyx_25040101_inst_pack_pkg;

    localparam logic [4:0] IMM_TYPE_I = 5'b10000;
    localparam logic [4:0] IMM_TYPE_S = 5'b01000;
    localparam logic [4:0] IMM_TYPE_B = 5'b00100;
    localparam logic [4:0] IMM_TYPE_U = 5'b00010;
    localparam logic [4:0] IMM_TYPE_J = 5'b00001;
    localparam logic [4:0] IMM_TYPE_R = 5'b00000;

    localparam logic [31:0] INST_ILLEGAL = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_R,
        SEL_I,
        SEL_S,
        SEL_B,
        SEL_U,
        SEL_J
    } imm_sel_e;

    // true when every bit of v at or above position lsb is the same value
    function automatic logic upper_uniform(input logic [31:0] v, input int lsb);
        logic all_one;
        logic all_zero;
        all_one  = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k >= lsb) begin
                all_one  = all_one & v[k];
                all_zero = all_zero & ~v[k];
            end
        end
        return all_one | all_zero;
    endfunction

endpackage

// File: rtl/ysyx_25040101_imm_scatter.sv
// rtl/ysyx_25040101_imm_scatter.sv - combinational immediate packer and range check (YSYX_25040101_PACK_CHECK_EN)
module ysyx_25040101_imm_scatter
    import ysyx_25040101_inst_pack_pkg::*;
(
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  imm_type_i,
    output logic [32:0] result_o
);

    imm_sel_e    sel;
    logic [31:0] inst;

`ifdef YSYX_25040101_PACK_CHECK_EN
    logic bad_type;
    logic range_err;

    // strict one-hot decode; anything other than a legal code is an error
    always_comb begin
        sel      = SEL_R;
        bad_type = 1'b0;
        case (imm_type_i)
            IMM_TYPE_I: sel = SEL_I;
            IMM_TYPE_S: sel = SEL_S;
            IMM_TYPE_B: sel = SEL_B;
            IMM_TYPE_U: sel = SEL_U;
            IMM_TYPE_J: sel = SEL_J;
            IMM_TYPE_R: sel = SEL_R;
            default:    bad_type = 1'b1;
        endcase
    end

    // immediate must be representable in the selected format
    always_comb begin
        range_err = 1'b0;
        case (sel)
            SEL_I, SEL_S: range_err = ~upper_uniform(imm_i, 11);
            SEL_B:        range_err = ~upper_uniform(imm_i, 12) | imm_i[0];
            SEL_U:        range_err = |imm_i[11:0];
            SEL_J:        range_err = ~upper_uniform(imm_i, 20) | imm_i[0];
            default:      range_err = 1'b0;
        endcase
    end

    // erroneous requests are replaced by the illegal instruction
    always_comb begin
        if (bad_type | range_err) begin
            result_o = {1'b1, INST_ILLEGAL};
        end else begin
            result_o = {1'b0, inst};
        end
    end
`else
    // priority decode so a malformed type still selects one format
    always_comb begin
        sel = SEL_R;
        if (imm_type_i[4]) begin
            sel = SEL_I;
        end else if (imm_type_i[3]) begin
            sel = SEL_S;
        end else if (imm_type_i[2]) begin
            sel = SEL_B;
        end else if (imm_type_i[1]) begin
            sel = SEL_U;
        end else if (imm_type_i[0]) begin
            sel = SEL_J;
        end
    end

    // no checking: out-of-range bits are simply dropped
    always_comb begin
        result_o = {1'b0, inst};
    end
`endif

    // scatter immediate bits over the base word
    always_comb begin
        inst = base_i;
        case (sel)
            SEL_I: inst[31:20] = imm_i[11:0];
            SEL_S: begin
                inst[31:25] = imm_i[11:5];
                inst[11:7]  = imm_i[4:0];
            end
            SEL_B: begin
                inst[31]    = imm_i[12];
                inst[7]     = imm_i[11];
                inst[30:25] = imm_i[10:5];
                inst[11:8]  = imm_i[4:1];
            end
            SEL_U: inst[31:12] = imm_i[31:12];
            SEL_J: begin
                inst[31]    = imm_i[20];
                inst[19:12] = imm_i[19:12];
                inst[20]    = imm_i[11];
                inst[30:21] = imm_i[10:1];
            end
            default: inst = base_i;
        endcase
    end

endmodule

// File: rtl/ysyx_25040101_inst_pack.sv
// rtl/ysyx_25040101_inst_pack.sv - instruction packer with 2-entry output queue (YSYX_25040101_PACK_CHECK_EN)
module ysyx_25040101_inst_pack
    import ysyx_25040101_inst_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  imm_type_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] inst_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

    logic [32:0] packed_entry;
    logic [31:0] mem_inst [2];
    logic        mem_err  [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    ysyx_25040101_imm_scatter u_scatter (
        .base_i     (base_i),
        .imm_i      (imm_i),
        .imm_type_i (imm_type_i),
        .result_o   (packed_entry)
    );

    assign in_ready_o  = (count != CNT_FULL);
    assign out_valid_o = (count != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // head is masked while empty so stale slots never leak out
    assign inst_o = out_valid_o ? mem_inst[rd_ptr] : '0;
    assign err_o  = out_valid_o & mem_err[rd_ptr];

    // queue storage, written at the tail on every accepted request
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= packed_entry[31:0];
            mem_err[wr_ptr]  <= packed_entry[32];
        end
    end

    // pointers and occupancy; reset flushes every queued entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef YSYX_25040101_PACK_CHECK_EN
    // saturating count of accepted requests that failed the check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_o <= 8'h00;
        end else if (push && packed_entry[32] && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'h01;
        end
    end
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_ysyx_25040101_inst_pack.sv
// tb/tb_ysyx_25040101_inst_pack.sv - directed self-checking bench for ysyx_25040101_inst_pack
module tb_ysyx_25040101_inst_pack;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] base_i;
    logic [31:0] imm_i;
    logic [4:0]  imm_type_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checks;
    int failures;

    ysyx_25040101_inst_pack #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .base_i      (base_i),
        .imm_i       (imm_i),
        .imm_type_i  (imm_type_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] t, input logic [31:0] b, input logic [31:0] im);
        in_valid_i = 1'b1;
        imm_type_i = t;
        base_i     = b;
        imm_i      = im;
    endtask

    function automatic logic [31:0] extend(input logic [31:0] i, input logic [4:0] t);
        case (t)
            5'b10000: return {{20{i[31]}}, i[31:20]};
            5'b01000: return {{20{i[31]}}, i[31:25], i[11:7]};
            5'b00100: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            5'b00010: return {i[31:12], 12'b0};
            5'b00001: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:  return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] im;
        logic [4:0]  t;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        base_i      = '0;
        imm_i       = '0;
        imm_type_i  = '0;

        step();
        step();
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);

        // single transactions, one cycle latency, consumer always ready
        out_ready_i = 1'b1;
        req(5'b10000, 32'h0000_0093, 32'hFFFF_FFFF);
        step();
        chk("i_valid", 32'(out_valid_o), 32'd1);
        chk("i_inst", inst_o, 32'hFFF0_0093);
        chk("i_err", 32'(err_o), 32'd0);
        req(5'b00100, 32'h0000_0063, 32'h0000_0008);
        step();
        chk("b_inst", inst_o, 32'h0000_0463);
        req(5'b00001, 32'h0000_00EF, 32'h0000_0800);
        step();
        chk("j_inst", inst_o, 32'h0010_00EF);
        req(5'b00010, 32'h0000_02B7, 32'h1234_5000);
        step();
        chk("u_inst", inst_o, 32'h1234_52B7);
        req(5'b01000, 32'h0000_0023, 32'hFFFF_FFFC);
        step();
        chk("s_inst", inst_o, 32'hFE00_0E23);
        req(5'b00000, 32'h00B5_0533, 32'hFFFF_FFFF);
        step();
        chk("r_inst", inst_o, 32'h00B5_0533);
        chk("r_err", 32'(err_o), 32'd0);

        // out-of-range B immediate and malformed type
        req(5'b00100, 32'h0000_0063, 32'h0000_0003);
        step();
`ifdef YSYX_25040101_PACK_CHECK_EN
        chk("berr_inst", inst_o, 32'h0000_0000);
        chk("berr_err", 32'(err_o), 32'd1);
        chk("berr_cnt", 32'(err_cnt_o), 32'd1);
`else
        chk("btrunc_inst", inst_o, 32'h0000_0163);
        chk("btrunc_err", 32'(err_o), 32'd0);
        chk("btrunc_cnt", 32'(err_cnt_o), 32'd0);
`endif
        req(5'b01100, 32'h0000_0023, 32'h0000_0001);
        step();
`ifdef YSYX_25040101_PACK_CHECK_EN
        chk("multihot_inst", inst_o, 32'h0000_0000);
        chk("multihot_err", 32'(err_o), 32'd1);
`else
        chk("multihot_inst", inst_o, 32'h0000_00A3);
        chk("multihot_err", 32'(err_o), 32'd0);
`endif

        // 300 bad requests saturate the error counter
        req(5'b00100, 32'h0000_0063, 32'h0000_0003);
        for (int n = 0; n < 300; n++) begin
            step();
        end
`ifdef YSYX_25040101_PACK_CHECK_EN
        chk("err_cnt_sat", 32'(err_cnt_o), 32'hFF);
`else
        chk("err_cnt_const", 32'(err_cnt_o), 32'h00);
`endif
        in_valid_i = 1'b0;
        step();
        chk("drain_empty", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b1;
        step();
        chk("empty_pop_ignored", 32'(in_ready_o), 32'd1);

        // backpressure: two absorbed, third held until a pop frees space
        out_ready_i = 1'b0;
        req(5'b10000, 32'h0000_0013, 32'h0000_0001);
        step();
        chk("bp_ready1", 32'(in_ready_o), 32'd1);
        req(5'b10000, 32'h0000_0013, 32'h0000_0002);
        step();
        chk("bp_full_ready", 32'(in_ready_o), 32'd0);
        req(5'b10000, 32'h0000_0013, 32'h0000_0003);
        step();
        chk("bp_held_ready", 32'(in_ready_o), 32'd0);
        chk("bp_head_a", inst_o, 32'h0010_0013);
        out_ready_i = 1'b1;
        step();
        chk("bp_head_b", inst_o, 32'h0020_0013);
        chk("bp_ready_after_pop", 32'(in_ready_o), 32'd1);
        step();
        chk("bp_head_c", inst_o, 32'h0030_0013);
        in_valid_i = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid_o), 32'd0);

        // asynchronous reset with a full queue
        out_ready_i = 1'b0;
        req(5'b10000, 32'h0000_0013, 32'h0000_0005);
        step();
        step();
        chk("rmid_full", 32'(in_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rmid_valid_now", 32'(out_valid_o), 32'd0);
        in_valid_i = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("rmid_in_ready", 32'(in_ready_o), 32'd1);
        out_ready_i = 1'b1;
        step();
        chk("rmid_no_stale", 32'(out_valid_o), 32'd0);
        chk("rmid_inst", inst_o, 32'h0);

        // round trip through the extender with in-range immediates
        for (int n = 0; n < 20; n++) begin
            r = $urandom;
            case (n % 5)
                0: begin t = 5'b10000; im = {{20{r[11]}}, r[11:0]}; end
                1: begin t = 5'b01000; im = {{20{r[11]}}, r[11:0]}; end
                2: begin t = 5'b00100; im = {{19{r[12]}}, r[12:1], 1'b0}; end
                3: begin t = 5'b00010; im = {r[31:12], 12'b0}; end
                default: begin t = 5'b00001; im = {{11{r[20]}}, r[20:1], 1'b0}; end
            endcase
            req(t, $urandom, im);
            step();
            chk("rt_imm", extend(inst_o, t), im);
            chk("rt_err", 32'(err_o), 32'd0);
            in_valid_i = 1'b0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25040101_inst_pack.md
# ysyx_25040101_inst_pack

Instruction packer: the encode-side counterpart of the core's immediate extender. It takes a 32-bit immediate, a one-hot immediate type and a base instruction word, and scatters the immediate into the RV32 I/S/B/U/J bit positions. Results pass through a 2-entry output FIFO with valid/ready handshakes on both sides. It sits between the debug/program-buffer injector and the instruction path. Its output, run back through the extender, must reproduce the input immediate.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: output queue depth; only 2 is supported.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  request accepted when `in_valid_i & in_ready_o`.
- `base_i`  in  32  opcode/rd/funct3/rs1/rs2/funct7 fields; immediate positions are overwritten.
- `imm_i`  in  32  immediate, already sign/shift-normalised as the extender outputs it (U carries bits [31:12]).
- `imm_type_i`  in  5  one-hot: 10000=I, 01000=S, 00100=B, 00010=U, 00001=J, 00000=R (no immediate).
- `out_valid_o`  out  1  FIFO head valid.
- `out_ready_i`  in  1  consumer pop.
- `inst_o`  out  32  packed instruction.
- `err_o`  out  1  head entry failed the range check.
- `err_cnt_o`  out  8  saturating count of rejected requests.

## Operation
- Packing, with all other bits taken from `base_i`:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
  - R: `base_i` unchanged.
- Range checks; failing any one flags the entry as an error:
  - I, S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - Any non-one-hot `imm_type_i` other than 00000.
- Error entry: stored with `inst_o`=32'h0000_0000 (illegal instruction) and `err_o`=1. `err_cnt_o` increments on acceptance and saturates at 8'hFF.
- FIFO: `count` takes values 0..2.
  - `in_ready_o` = (count != 2), driven from registers only.
  - Push and pop in the same cycle at count 1 leaves count at 1 with order preserved.
  - At count 0 a push is never bypassed to the output.
  - `out_valid_o` = (count != 0).
  - Pop when `out_valid_o & out_ready_i`; an `out_ready_i` pulse while empty is ignored.
  - Read/write pointers are 1 bit and wrap.

## Timing
- Latency: a request accepted at edge N appears on `inst_o` after edge N, i.e. visible in cycle N+1. Throughput is 1 per cycle while `out_ready_i`=1.
- Under backpressure, two requests are absorbed. `in_ready_o` drops in the cycle after the second acceptance and rises in the cycle after a pop.
- Reset values: `out_valid_o`=0, `inst_o`=0, `err_o`=0, `err_cnt_o`=0, count=0, pointers=0. `in_ready_o`=1 once `rst` deasserts.
- Reset mid-operation discards all queued entries immediately (asynchronous). No entry survives.
- Holding `out_valid_o`: `inst_o` and `err_o` stay stable until popped.

## Configuration
- `YSYX_25040101_PACK_CHECK_EN` defined: range checks, error substitution, `err_o` and `err_cnt_o` behave as above.
- Not defined:
  - No checks are performed; `err_o`=0 and `err_cnt_o`=0 are constants.
  - Out-of-range bits are silently truncated.
  - A non-one-hot type resolves by priority I>S>B>U>J.

## Structure
- Shared package holds:
  - `IMM_TYPE_{I,S,B,U,J,R}` one-hot constants, shared with the control unit and extender.
  - `INST_ILLEGAL` = 32'h0.
- Sub-module `ysyx_25040101_imm_scatter`: combinational packer plus range check, producing `{err, inst}`.
- The top module holds the FIFO, handshakes and the error counter.

## Test plan
- I, base 32'h0000_0093, imm 32'hFFFF_FFFF, `out_ready_i`=1 → next cycle `inst_o`=32'hFFF0_0093, `err_o`=0.
- B, base 32'h0000_0063, imm 8 → 32'h0000_0463.
- J, base 32'h0000_00EF, imm 32'h800 → 32'h0010_00EF.
- U, base 32'h0000_02B7, imm 32'h1234_5000 → 32'h1234_52B7.
- Error path (check enabled):
  - B imm 3 → `inst_o`=0, `err_o`=1, `err_cnt_o`=1.
  - 300 such requests → `err_cnt_o`=8'hFF.
- Backpressure, `out_ready_i`=0, offer 3 requests → 2 accepted, `in_ready_o`=0, third held. Then raise `out_ready_i` → outputs in order, third accepted a cycle after the first pop.
- Reset mid-operation: assert `rst` with count=2 → `out_valid_o`=0 immediately, and no stale entry appears after release.
- Round-trip: random imm/type in range → extender(`inst_o`[31:7], type) equals `imm_i`.
